// File: rtl/vga_pixel_fifo_if.sv
// Write/read handshake bundle between a pixel source, vga_pixel_fifo and vga_ctrl.
// The FIFO uses the slave modport. The source/consumer side uses the master modport.
interface vga_pixel_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  flush_i;
  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic [LVL_W-1:0]      level_o;
  logic                  underflow_o;

  modport master (
    output flush_i, wr_valid_i, wr_data_i, rd_en_i,
    input  wr_ready_o, rd_data_o, empty_o, almost_empty_o, level_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, rd_en_i,
    output wr_ready_o, rd_data_o, empty_o, almost_empty_o, level_o, underflow_o
  );
endinterface

// File: rtl/vga_pixel_fifo.sv
// First-word-fall-through RGB565 pixel FIFO in the pixel clock domain.
// It has a per-frame flush and a sticky underflow flag.
module vga_pixel_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 64,
  parameter int AEMPTY_LEVEL = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  vga_pixel_fifo_if.slave fifo
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  accept, pop, mem_we;

  assign accept = fifo.wr_valid_i & wr_ready_q;
  assign pop    = fifo.rd_en_i & ~empty_q;
  assign mem_we = accept & ~fifo.flush_i & ~rst_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;
    if (fifo.flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !pop)      level_d = level_q + 1'b1;
      else if (pop && !accept) level_d = level_q - 1'b1;
      if (fifo.rd_en_i && empty_q) underflow_d = 1'b1;
    end
    // Extra pointer MSB distinguishes full from empty, so equal pointers mean empty.
    empty_d    = (wr_ptr_d == rd_ptr_d);
    aempty_d   = (level_d <= AEMPTY_LVL);
    wr_ready_d = (level_d != FULL_LVL);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      underflow_q <= underflow_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q[PTR_W-1:0]] <= fifo.wr_data_i;
  end

  assign fifo.rd_data_o      = empty_q ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign fifo.empty_o        = empty_q;
  assign fifo.almost_empty_o = aempty_q;
  assign fifo.level_o        = level_q;
  assign fifo.underflow_o    = underflow_q;
  assign fifo.wr_ready_o     = wr_ready_q;
endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo.
// A queue model is compared every cycle, and directed literal checks pin the model.
module tb_vga_pixel_fifo;
  localparam int DW     = 16;
  localparam int DEPTH  = 64;
  localparam int AEMPTY = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pixel_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifo_if ();

  vga_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AEMPTY_LEVEL(AEMPTY)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fifo  (fifo_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: the stored words as a queue, plus ready and sticky-underflow bits.
  logic [DW-1:0] mq[$];
  logic m_ready   = 1'b0;
  logic m_uf      = 1'b0;
  logic model_on  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_uf     <= 1'b0;
      m_ready  <= 1'b0;
      model_on <= 1'b1;
    end else if (fifo_if.flush_i) begin
      mq.delete();
      m_uf    <= 1'b0;
      m_ready <= 1'b1;
    end else begin
      if (fifo_if.rd_en_i && mq.size() == 0) m_uf <= 1'b1;
      if (fifo_if.rd_en_i && mq.size() != 0) void'(mq.pop_front());
      if (fifo_if.wr_valid_i && m_ready) mq.push_back(fifo_if.wr_data_i);
      m_ready <= (mq.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_empty",  32'(fifo_if.empty_o),        32'(mq.size() == 0));
      check("m_level",  32'(fifo_if.level_o),        32'(mq.size()));
      check("m_aempty", 32'(fifo_if.almost_empty_o), 32'(mq.size() <= AEMPTY));
      check("m_rdata",  32'(fifo_if.rd_data_o),      (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("m_ready",  32'(fifo_if.wr_ready_o),     32'(m_ready));
      check("m_uflow",  32'(fifo_if.underflow_o),    32'(m_uf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    fifo_if.flush_i    = 1'b0;
    fifo_if.wr_valid_i = 1'b0;
    fifo_if.wr_data_i  = '0;
    fifo_if.rd_en_i    = 1'b0;

    // Reset release
    repeat (3) step();
    check("rst_ready", 32'(fifo_if.wr_ready_o), 32'h0);
    check("rst_empty", 32'(fifo_if.empty_o), 32'h1);
    check("rst_level", 32'(fifo_if.level_o), 32'h0);
    check("rst_rdata", 32'(fifo_if.rd_data_o), 32'h0);
    rst = 1'b0;
    step();
    check("rel_ready", 32'(fifo_if.wr_ready_o), 32'h1);

    // Fill to full with 0x0001..0x0040, then offer 0xFFFF which must be refused
    fifo_if.wr_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_if.wr_data_i = DW'(i + 1);
      step();
    end
    check("full_level", 32'(fifo_if.level_o), 32'd64);
    check("full_ready", 32'(fifo_if.wr_ready_o), 32'h0);
    fifo_if.wr_data_i = 16'hFFFF;
    repeat (2) step();
    fifo_if.wr_valid_i = 1'b0;
    check("full_hold", 32'(fifo_if.level_o), 32'd64);

    // Drain: FWFT order; a write offered with the first pop is still refused
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(fifo_if.rd_data_o), 32'(i + 1));
      if (i == 56) check("aempty_at8", 32'(fifo_if.almost_empty_o), 32'h1);
      if (i == 55) check("aempty_at9", 32'(fifo_if.almost_empty_o), 32'h0);
      if (i == 0) begin
        fifo_if.wr_valid_i = 1'b1;
        fifo_if.wr_data_i  = 16'hFFFF;
      end
      fifo_if.rd_en_i = 1'b1;
      step();
      if (i == 0) begin
        fifo_if.wr_valid_i = 1'b0;
        check("pop_full_level", 32'(fifo_if.level_o), 32'd63);
        check("pop_full_ready", 32'(fifo_if.wr_ready_o), 32'h1);
      end
    end
    fifo_if.rd_en_i = 1'b0;
    check("drained_empty", 32'(fifo_if.empty_o), 32'h1);
    check("drained_rdata", 32'(fifo_if.rd_data_o), 32'h0);

    // Steady state at level 5 across several pointer wraps
    fifo_if.wr_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fifo_if.wr_data_i = DW'(16'h0100 + i);
      step();
    end
    check("lvl5_start", 32'(fifo_if.level_o), 32'd5);
    fifo_if.rd_en_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      fifo_if.wr_data_i = DW'(16'h0105 + i);
      check("lvl5_data", 32'(fifo_if.rd_data_o), 32'(16'h0100 + i));
      step();
      check("lvl5_level", 32'(fifo_if.level_o), 32'd5);
    end
    fifo_if.wr_valid_i = 1'b0;
    repeat (5) step();
    fifo_if.rd_en_i = 1'b0;
    check("lvl5_empty", 32'(fifo_if.empty_o), 32'h1);

    // Underflow with a simultaneous write
    fifo_if.rd_en_i    = 1'b1;
    fifo_if.wr_valid_i = 1'b1;
    fifo_if.wr_data_i  = 16'h1234;
    step();
    fifo_if.rd_en_i    = 1'b0;
    fifo_if.wr_valid_i = 1'b0;
    check("uf_flag",  32'(fifo_if.underflow_o), 32'h1);
    check("uf_level", 32'(fifo_if.level_o), 32'd1);
    check("uf_rdata", 32'(fifo_if.rd_data_o), 32'h1234);
    repeat (3) step();
    check("uf_sticky", 32'(fifo_if.underflow_o), 32'h1);
    fifo_if.flush_i = 1'b1;
    step();
    fifo_if.flush_i = 1'b0;
    check("uf_cleared", 32'(fifo_if.underflow_o), 32'h0);
    check("uf_flush_lvl", 32'(fifo_if.level_o), 32'd0);

    // Flush at level 20 with a concurrent write and pop
    fifo_if.wr_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fifo_if.wr_data_i = DW'(16'h2000 + i);
      step();
    end
    check("fl_level20", 32'(fifo_if.level_o), 32'd20);
    fifo_if.flush_i   = 1'b1;
    fifo_if.rd_en_i   = 1'b1;
    fifo_if.wr_data_i = 16'hBEEF;
    step();
    fifo_if.flush_i    = 1'b0;
    fifo_if.rd_en_i    = 1'b0;
    fifo_if.wr_valid_i = 1'b0;
    check("fl_level", 32'(fifo_if.level_o), 32'd0);
    check("fl_empty", 32'(fifo_if.empty_o), 32'h1);
    check("fl_uflow", 32'(fifo_if.underflow_o), 32'h0);
    check("fl_ready", 32'(fifo_if.wr_ready_o), 32'h1);
    check("fl_rdata", 32'(fifo_if.rd_data_o), 32'h0);
    step();
    check("fl_not_stored", 32'(fifo_if.level_o), 32'd0);

    // Reset at level 20 with a concurrent write
    fifo_if.wr_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fifo_if.wr_data_i = DW'(16'h3000 + i);
      step();
    end
    check("rs_level20", 32'(fifo_if.level_o), 32'd20);
    rst = 1'b1;
    fifo_if.wr_data_i = 16'hCAFE;
    step();
    check("rs_level", 32'(fifo_if.level_o), 32'd0);
    check("rs_empty", 32'(fifo_if.empty_o), 32'h1);
    check("rs_ready", 32'(fifo_if.wr_ready_o), 32'h0);
    check("rs_rdata", 32'(fifo_if.rd_data_o), 32'h0);
    step();
    check("rs_ready_hold", 32'(fifo_if.wr_ready_o), 32'h0);
    rst = 1'b0;
    fifo_if.wr_valid_i = 1'b0;
    step();
    check("rs_ready_rel", 32'(fifo_if.wr_ready_o), 32'h1);
    check("rs_not_stored", 32'(fifo_if.level_o), 32'd0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_pixel_fifo.md
# vga_pixel_fifo

Synchronous first-word-fall-through pixel FIFO that decouples the picture source from `vga_ctrl`. It accepts RGB565 words through a valid/ready write port. Its `rd_data_o` and `empty_o` outputs drive `vga_ctrl.fifo_data_i` and `fifo_empty_i`. The active-video strobe (`hde && vde`) drives `rd_en_i` to pop one pixel per displayed clock. It runs entirely in the pixel clock domain, with a per-frame flush for resynchronisation and a sticky underflow flag for diagnostics (LED/7-seg).

## Interface
Parameters:
- `DATA_WIDTH`, default 16: pixel word width (`rgb565_t`).
- `DEPTH`, default 64: number of entries. Must be a power of two and ≥ 4. Storage is register-based.
- `AEMPTY_LEVEL`, default 8: `almost_empty_o` threshold. Range 0 … DEPTH-1.

Ports:
- `clk_i`  in  1  pixel clock. This is the block's only clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `flush_i`  in  1  synchronous clear of contents and flags (typically `eof`).
- `wr_valid_i`  in  1  write request.
- `wr_data_i`  in  DATA_WIDTH  write data.
- `wr_ready_o`  out  1  FIFO can accept a word this cycle. Registered.
- `rd_en_i`  in  1  pop the head word. Asserted by the consumer while displaying.
- `rd_data_o`  out  DATA_WIDTH  head word. Valid whenever `empty_o`=0, and forced to 0 when empty.
- `empty_o`  out  1  no stored words.
- `almost_empty_o`  out  1  `level_o` ≤ AEMPTY_LEVEL.
- `level_o`  out  $clog2(DEPTH)+1  number of stored words, 0 … DEPTH.
- `underflow_o`  out  1  sticky flag: a pop was attempted while empty.

## Operation
- **Write accept:** a write is accepted when `wr_valid_i & wr_ready_o`. The word is stored at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
  - `wr_valid_i` while `wr_ready_o`=0 is ignored. No data is lost silently, because the source must hold valid.
- **Pop:** a pop occurs when `rd_en_i & ~empty_o`, and `rd_ptr` increments modulo DEPTH.
  - `rd_en_i` while `empty_o`=1 performs no pop and sets `underflow_o`.
- **Level:** `level_o` increments on accept-only, decrements on pop-only, and is unchanged when both or neither occur.
  - Pointers carry one extra MSB. Full is `wr_ptr` == `rd_ptr` with the MSBs differing. Empty is `wr_ptr` == `rd_ptr` exactly.
- **Full:** `wr_ready_o` = ~(next level == DEPTH), registered.
  - A pop while full does not allow a write in the same cycle. `wr_ready_o` rises the cycle after the pop.
- **Empty:** a write into an empty FIFO is accepted. A simultaneous `rd_en_i` in that cycle counts as an underflow, and the written word remains.
- **FWFT head:** `rd_data_o` = mem[`rd_ptr`] combinationally when not empty, and 0 when empty (black pixel to the DAC).
- **Flush:** `flush_i` resets pointers and level to 0, clears `underflow_o`, and sets `wr_ready_o`=1.
  - Any write or pop in the same cycle is discarded.
  - Memory contents are not cleared.
- **Priority:** `rst_i` > `flush_i` > normal operation.

## Timing
- **Reset values (in the cycle after a `rst_i` edge):**
  - `empty_o`=1, `almost_empty_o`=1, `level_o`=0, `underflow_o`=0, `rd_data_o`=0.
  - `wr_ready_o`=0 while `rst_i` is high, and 1 on the first cycle after `rst_i` falls.
- **Reset mid-operation:** discards all stored words within one cycle. There is no partial state.
- **Write-to-read latency:** 1 cycle. A word accepted at edge N makes `empty_o`=0, with `rd_data_o` equal to that word, after edge N.
- **Read throughput:** back-to-back pops, 1 word per clock. After a pop at edge N, `rd_data_o` presents the next word after edge N.
- **Flags:** `level_o`, `empty_o`, `almost_empty_o` and `underflow_o` are registered and update on the same edge as the pointer change.
- **Wrap-around:** pointers wrap at DEPTH with no bubble. The data order is preserved across the wrap.
- **`underflow_o`:** sets on the edge following the offending cycle. It holds until `flush_i` or `rst_i`.

## Test plan
- **Reset release:** `rst_i` high 3 cycles, then low → `empty_o`=1, `level_o`=0, `rd_data_o`=0; `wr_ready_o`=0 during reset and 1 one cycle after.
- **Fill to full:** write 0x0001…0x0040 with no reads (DEPTH=64) → `level_o`=64 and `wr_ready_o`=0 after the 64th accept. A 65th valid word 0xFFFF is not stored.
- **Drain and FWFT ordering:** from full, hold `rd_en_i` 64 cycles → `rd_data_o` sequence 0x0001…0x0040, then `empty_o`=1 and `rd_data_o`=0. `almost_empty_o` rises when `level_o` reaches 8.
- **Simultaneous read/write at level 5 for 200 cycles with an incrementing pattern:**
  - `level_o` stays 5.
  - Output sequence equals input delayed by 5 words, with no corruption across pointer wrap.
- **Underflow:** `rd_en_i`=1 on an empty FIFO, with a write of 0x1234 the same cycle → `underflow_o`=1 next cycle, `level_o`=1, `rd_data_o`=0x1234. `underflow_o` stays 1 until `flush_i`.
- **Flush and reset mid-operation:**
  - At level 20, assert `flush_i` together with a valid write → next cycle `level_o`=0, `empty_o`=1, `underflow_o`=0, and the written word is not stored.
  - Repeat with `rst_i` → same result, plus `wr_ready_o`=0 during reset.
